// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: four-way next-PC select (exception, branch,
// jump/return, sequential) with a circular return-address stack for jr $ra.
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              INCR      = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = 32'h8000_0180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         PCen,
    input  logic                         exc_valid,
    input  logic                         branch_taken,
    input  logic [PC_W-1:0]              branch_target,
    input  logic                         jump_valid,
    input  logic [PC_W-1:0]              jump_target,
    input  logic                         call,
    input  logic [PC_W-1:0]              link_addr,
    input  logic                         ret,
    input  logic [PC_W-1:0]              ret_fallback,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              npc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         align_err
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INCR - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  r_pc;
    logic             r_align_err;
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    logic [PC_W-1:0]  w_npc;
    logic             w_empty;
    logic             w_full;
    logic [PC_W-1:0]  w_ret_tgt;
    logic [PC_W-1:0]  w_raw_tgt;
    logic             w_load;
    logic             w_ras_op;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_npc   = r_pc + PC_W'(INCR);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // Return target comes from pre-edge stack state.
    assign w_ret_tgt = w_empty ? ret_fallback : r_ras[r_top];

    always_comb begin
        w_raw_tgt = jump_target;
        if (branch_taken) begin
            w_raw_tgt = branch_target;
        end else if (ret) begin
            w_raw_tgt = w_ret_tgt;
        end
    end

    // A target is loaded only on an enabled, non-exception branch or jump cycle.
    assign w_load   = !exc_valid && PCen && (branch_taken || jump_valid);
    assign w_ras_op = !exc_valid && PCen && !branch_taken && jump_valid;
    assign w_push   = w_ras_op && call;
    assign w_pop    = w_ras_op && ret;

    always_comb begin
        w_top_nxt = r_top;
        w_cnt_nxt = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_top + PTR_W'(1);
        if (w_push && w_pop) begin
            w_wr_en = 1'b1;
            if (w_empty) begin
                w_top_nxt = r_top + PTR_W'(1);
                w_cnt_nxt = CNT_W'(1);
            end else begin
                // Pop then push lands back in the slot just freed.
                w_wr_idx = r_top;
            end
        end else if (w_push) begin
            w_wr_en   = 1'b1;
            w_top_nxt = r_top + PTR_W'(1);
            if (!w_full) begin
                w_cnt_nxt = r_count + CNT_W'(1);
            end
        end else if (w_pop && !w_empty) begin
            w_top_nxt = r_top - PTR_W'(1);
            w_cnt_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc        <= RESET_VEC;
            r_align_err <= 1'b0;
            r_top       <= '0;
            r_count     <= '0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_cnt_nxt;
            if (exc_valid) begin
                r_pc        <= EXC_VEC;
                r_align_err <= 1'b0;
            end else if (!PCen) begin
                r_align_err <= 1'b0;
            end else if (w_load) begin
                r_pc        <= w_raw_tgt & ~ALIGN_MASK;
                r_align_err <= |(w_raw_tgt & ALIGN_MASK);
            end else begin
                r_pc        <= w_npc;
                r_align_err <= 1'b0;
            end
        end
    end

    // Stack payload carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge CLK) begin
        if (w_wr_en && !RST) begin
            r_ras[w_wr_idx] <= link_addr;
        end
    end

    assign pc        = r_pc;
    assign npc       = w_npc;
    assign ras_count = r_count;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequencing, stall/exception,
// priority, RAS overflow/underflow, call+ret, alignment and wrap.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PCen;
    logic        exc_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        call;
    logic [31:0] link_addr;
    logic        ret;
    logic [31:0] ret_fallback;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        align_err;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .PCen         (PCen),
        .exc_valid    (exc_valid),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .call         (call),
        .link_addr    (link_addr),
        .ret          (ret),
        .ret_fallback (ret_fallback),
        .pc           (pc),
        .npc          (npc),
        .ras_count    (ras_count),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .align_err    (align_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        RST = 0; PCen = 0; exc_valid = 0; branch_taken = 0; branch_target = 0;
        jump_valid = 0; jump_target = 0; call = 0; link_addr = 0; ret = 0;
        ret_fallback = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1; exc_valid = 1; PCen = 1;
        tick();
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (npc !== 32'h4) begin failures++; $display("FAIL reset_npc: got %h want %h", npc, 32'h4); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", ras_count); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin failures++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", ras_empty, ras_full); end
        checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL reset_align: got %b want 0", align_err); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        PCen = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc[i]); end
        end
        checks++; if (npc !== 32'h10) begin failures++; $display("FAIL seq_npc: got %h want %h", npc, 32'h10); end
    endtask

    task automatic test_stall_exception();
        PCen = 0; jump_valid = 1; jump_target = 32'h100;
        tick();
        checks++; if (pc !== 32'hC) begin failures++; $display("FAIL stall_hold: got %h want %h", pc, 32'hC); end
        exc_valid = 1; ret = 1; call = 1; link_addr = 32'h44;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h8000_0180) begin failures++; $display("FAIL exc_vec: got %h want %h", pc, 32'h8000_0180); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL exc_ras: got %0d want 0", ras_count); end
    endtask

    task automatic test_priority();
        PCen = 1; branch_taken = 1; branch_target = 32'h40;
        jump_valid = 1; jump_target = 32'h800; call = 1; link_addr = 32'h99C;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL prio_pc: got %h want %h", pc, 32'h40); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL prio_ras: got %0d want 0", ras_count); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [5] = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h777C};
        PCen = 1; jump_valid = 1; call = 1; jump_target = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            link_addr = 32'h10 * (i + 1);
            tick();
        end
        checks++; if (pc !== 32'h2000) begin failures++; $display("FAIL call_pc: got %h want %h", pc, 32'h2000); end
        checks++; if (ras_count !== 3'd4 || ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full: count=%0d full=%b want 4 1", ras_count, ras_full); end
        call = 0; ret = 1; ret_fallback = 32'h777C;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (pc !== exp_ret[i]) begin failures++; $display("FAIL ret_pc[%0d]: got %h want %h", i, pc, exp_ret[i]); end
        end
        checks++; if (ras_count !== 3'd0 || ras_empty !== 1'b1) begin failures++; $display("FAIL unf_empty: count=%0d empty=%b want 0 1", ras_count, ras_empty); end
        clear_inputs();
    endtask

    task automatic test_call_ret();
        PCen = 1; jump_valid = 1; call = 1; link_addr = 32'h200; jump_target = 32'h3000;
        tick();
        ret = 1; link_addr = 32'h300; ret_fallback = 32'h777C;
        tick();
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL cr_pc: got %h want %h", pc, 32'h200); end
        checks++; if (ras_count !== 3'd1) begin failures++; $display("FAIL cr_count: got %0d want 1", ras_count); end
        call = 0;
        tick();
        checks++; if (pc !== 32'h300) begin failures++; $display("FAIL cr_top: got %h want %h", pc, 32'h300); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL cr_pop: got %0d want 0", ras_count); end
        call = 1; link_addr = 32'h500;
        tick();
        checks++; if (pc !== 32'h777C || ras_count !== 3'd1) begin failures++; $display("FAIL cr_empty: pc=%h count=%0d want 777c 1", pc, ras_count); end
        call = 0;
        tick();
        checks++; if (pc !== 32'h500) begin failures++; $display("FAIL cr_empty_pop: got %h want %h", pc, 32'h500); end
        clear_inputs();
    endtask

    task automatic test_align_wrap();
        PCen = 1; jump_valid = 1; jump_target = 32'h1003;
        tick();
        checks++; if (pc !== 32'h1000 || align_err !== 1'b1) begin failures++; $display("FAIL align_jump: pc=%h err=%b want 1000 1", pc, align_err); end
        jump_valid = 0;
        tick();
        checks++; if (pc !== 32'h1004 || align_err !== 1'b0) begin failures++; $display("FAIL align_pulse: pc=%h err=%b want 1004 0", pc, align_err); end
        branch_taken = 1; branch_target = 32'h2002;
        tick();
        checks++; if (pc !== 32'h2000 || align_err !== 1'b1) begin failures++; $display("FAIL align_branch: pc=%h err=%b want 2000 1", pc, align_err); end
        branch_taken = 0; PCen = 0;
        tick();
        checks++; if (pc !== 32'h2000 || align_err !== 1'b0) begin failures++; $display("FAIL align_stall: pc=%h err=%b want 2000 0", pc, align_err); end
        PCen = 1; jump_valid = 1; jump_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (npc !== 32'h0 || align_err !== 1'b0) begin failures++; $display("FAIL wrap_npc: npc=%h err=%b want 0 0", npc, align_err); end
        jump_valid = 0;
        tick();
        checks++; if (pc !== 32'h0 || npc !== 32'h4) begin failures++; $display("FAIL wrap_pc: pc=%h npc=%h want 0 4", pc, npc); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        PCen = 1; jump_valid = 1; call = 1; jump_target = 32'h4000; link_addr = 32'h60;
        tick();
        call = 0; ret = 1; exc_valid = 1;
        tick();
        checks++; if (pc !== 32'h8000_0180 || ras_count !== 3'd1) begin failures++; $display("FAIL exc_keep: pc=%h count=%0d want 80000180 1", pc, ras_count); end
        exc_valid = 0;
        tick();
        checks++; if (pc !== 32'h60) begin failures++; $display("FAIL exc_keep_ret: got %h want %h", pc, 32'h60); end
        ret = 0; call = 1; link_addr = 32'hA0;
        tick();
        link_addr = 32'hB0;
        tick();
        RST = 1; exc_valid = 1; call = 0; ret = 1;
        tick();
        checks++; if (pc !== 32'h0 || ras_count !== 3'd0) begin failures++; $display("FAIL mid_reset: pc=%h count=%0d want 0 0", pc, ras_count); end
        RST = 0; exc_valid = 0; ret_fallback = 32'h1234;
        tick();
        checks++; if (pc !== 32'h1234 || ras_count !== 3'd0) begin failures++; $display("FAIL mid_reset_ret: pc=%h count=%0d want 1234 0", pc, ras_count); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_sequential();
        test_stall_exception();
        test_priority();
        test_ras_overflow();
        test_call_ret();
        test_align_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
